// File: rtl/dcache_blocking_pkg.sv
// Shared types for the blocking dcache pipe and its requester arbiter.
package dcache_blocking_pkg;

    localparam int OP_W   = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_FLUSH = 2'd2,
        OP_NOP   = 2'd3
    } op_t;

    typedef logic [DATA_W-1:0] data_t;

    // Arbiter support: requester IDs are sized for the largest supported N.
    localparam int ARB_N_MAX = 8;
    localparam int ARB_ID_W  = (ARB_N_MAX > 1) ? $clog2(ARB_N_MAX) : 1;

    typedef logic [ARB_ID_W-1:0] arb_id_t;

    typedef struct packed {
        op_t               op;
        logic [ADDR_W-1:0] addr;
        data_t             data;
    } arb_req_t;

endpackage

// File: rtl/dcache_blocking_fifo.sv
// Small in-order FIFO used by the dcache pipe and its arbiter.
// Pointers wrap by comparing against N-1, so any depth works.
// HAS_REPLAY selects replay support; this copy provides the plain queue only,
// which is what the arbiter's ID queue needs (HAS_REPLAY=0).
module dcache_blocking_fifo #(
    parameter int W          = 8,
    parameter int N          = 8,
    parameter int HAS_REPLAY = 0,
    localparam int CNT_W     = $clog2(N + 1),
    localparam int PTR_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [N];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_s;
    logic             pop_s;

    generate
        if (HAS_REPLAY != 0) begin : g_replay
            // Replay rewind is not built into this queue; instantiate with HAS_REPLAY=0.
        end
    endgenerate

    assign full_o  = (cnt_q == CNT_W'(N));
    assign empty_o = (cnt_q == {CNT_W{1'b0}});
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_s  = push_i & ~full_o;
    assign pop_s   = pop_i & ~empty_o;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(N - 1)) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(N - 1)) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/dcache_blocking_rr_arb.sv
// Combinational N-way round-robin picker: searches req upward from ptr
// (mod N) and returns a one-hot grant, the winner index and the next pointer.
module dcache_blocking_rr_arb #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             found_o,
    output logic [PTR_W-1:0] ptr_nxt_o
);

    logic [PTR_W-1:0] idx_s;

    // Walk the ring once from the pointer, keeping the first requester seen.
    always_comb begin
        grant_o   = {N{1'b0}};
        idx_o     = ptr_i;
        found_o   = 1'b0;
        ptr_nxt_o = ptr_i;
        idx_s     = ptr_i;
        for (int k = 0; k < N; k++) begin
            if (!found_o && req_i[idx_s]) begin
                found_o        = 1'b1;
                grant_o[idx_s] = 1'b1;
                idx_o          = idx_s;
                ptr_nxt_o      = (idx_s == PTR_W'(N - 1)) ? {PTR_W{1'b0}} : idx_s + PTR_W'(1);
            end else begin
                found_o = found_o;
            end
            idx_s = (idx_s == PTR_W'(N - 1)) ? {PTR_W{1'b0}} : idx_s + PTR_W'(1);
        end
    end

endmodule

// File: rtl/dcache_blocking_arb.sv
// Round-robin arbiter sharing the blocking dcache pipe's fetch port between
// N requesters; an in-order ID queue routes each commit back to its requester.
// Optional build macro DCACHE_BLOCKING_ARB_STATS_EN adds grant counters and
// starvation flags.
module dcache_blocking_arb
    import dcache_blocking_pkg::*;
#(
    parameter int N    = 2,
    parameter int ID_N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req_valid,
    input  logic [N*OP_W-1:0]   req_op,
    input  logic [N*ADDR_W-1:0] req_addr,
    input  logic [N*DATA_W-1:0] req_data,
    output logic [N-1:0]        req_accept,
    output logic                fetch_valid,
    output logic [OP_W-1:0]     fetch_op,
    output logic [ADDR_W-1:0]   fetch_addr,
    output logic [DATA_W-1:0]   fetch_data,
    input  logic                fetch_accept,
    input  logic                commit_valid_r,
    input  logic                commit_load_r,
    input  logic [DATA_W-1:0]   commit_data_r,
    output logic                commit_accept,
    output logic [N-1:0]        rsp_valid_r,
    output logic                rsp_load_r,
    output logic [DATA_W-1:0]   rsp_data_r,
    output logic                busy_r,
`ifdef DCACHE_BLOCKING_ARB_STATS_EN
    output logic [N*32-1:0]     grant_cnt_r,
    output logic [N-1:0]        starve_r,
`endif
    output logic                err_r
);

    localparam int ID_W  = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(ID_N + 1);

    arb_req_t         req_s [N];
    arb_req_t         slot_q;
    logic             slot_valid_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [N-1:0]     grant_s;
    logic [ID_W-1:0]  win_idx_s;
    logic             found_s;
    logic [ID_W-1:0]  rr_ptr_d;
    logic             arb_en_s;
    logic             grant_fire_s;
    logic             idq_full_s;
    logic             idq_empty_s;
    logic [CNT_W-1:0] idq_cnt_s;
    logic [CNT_W-1:0] idq_cnt_d;
    arb_id_t          idq_head_s;
    logic             pop_s;
    logic [N-1:0]     rsp_valid_q;
    logic             rsp_load_q;
    data_t            rsp_data_q;
    logic             busy_q;
    logic             err_q;

    // Unpack the flat per-requester buses into request structs.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_s[i].op   = op_t'(req_op[i*OP_W +: OP_W]);
            req_s[i].addr = req_addr[i*ADDR_W +: ADDR_W];
            req_s[i].data = req_data[i*DATA_W +: DATA_W];
        end
    end

    dcache_blocking_rr_arb #(
        .N     (N),
        .PTR_W (ID_W)
    ) u_rr_arb (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .grant_o   (grant_s),
        .idx_o     (win_idx_s),
        .found_o   (found_s),
        .ptr_nxt_o (rr_ptr_d)
    );

    // A full ID queue blocks grants even when a commit pops this cycle.
    assign arb_en_s     = (~slot_valid_q | fetch_accept) & ~idq_full_s;
    assign grant_fire_s = arb_en_s & found_s;
    assign pop_s        = commit_valid_r & ~idq_empty_s;
    assign idq_cnt_d    = idq_cnt_s + CNT_W'(grant_fire_s) - CNT_W'(pop_s);

    // Expose the grant only when the slot and ID queue can take it.
    always_comb begin
        if (arb_en_s) begin
            req_accept = grant_s;
        end else begin
            req_accept = {N{1'b0}};
        end
    end

    dcache_blocking_fifo #(
        .W          (ARB_ID_W),
        .N          (ID_N),
        .HAS_REPLAY (0)
    ) u_idq (
        .clk     (clk),
        .rst     (rst),
        .push_i  (grant_fire_s),
        .wdata_i (ARB_ID_W'(win_idx_s)),
        .pop_i   (pop_s),
        .rdata_o (idq_head_s),
        .full_o  (idq_full_s),
        .empty_o (idq_empty_s),
        .count_o (idq_cnt_s)
    );

    // Output slot, round-robin pointer, response routing and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_q <= 1'b0;
            slot_q       <= '{op: OP_LOAD, addr: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
            rr_ptr_q     <= {ID_W{1'b0}};
            rsp_valid_q  <= {N{1'b0}};
            rsp_load_q   <= 1'b0;
            rsp_data_q   <= {DATA_W{1'b0}};
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (grant_fire_s) begin
                slot_valid_q <= 1'b1;
                slot_q       <= req_s[win_idx_s];
                rr_ptr_q     <= rr_ptr_d;
            end else if (fetch_accept) begin
                slot_valid_q <= 1'b0;
            end else begin
                slot_valid_q <= slot_valid_q;
            end
            if (pop_s) begin
                rsp_valid_q <= {{(N-1){1'b0}}, 1'b1} << idq_head_s;
                rsp_load_q  <= commit_load_r;
                rsp_data_q  <= commit_data_r;
            end else begin
                rsp_valid_q <= {N{1'b0}};
            end
            busy_q <= (idq_cnt_d != {CNT_W{1'b0}});
            err_q  <= err_q | (commit_valid_r & idq_empty_s);
        end
    end

    assign fetch_valid   = slot_valid_q;
    assign fetch_op      = slot_q.op;
    assign fetch_addr    = slot_q.addr;
    assign fetch_data    = slot_q.data;
    assign commit_accept = 1'b1;
    assign rsp_valid_r   = rsp_valid_q;
    assign rsp_load_r    = rsp_load_q;
    assign rsp_data_r    = rsp_data_q;
    assign busy_r        = busy_q;
    assign err_r         = err_q;

`ifdef DCACHE_BLOCKING_ARB_STATS_EN
    localparam int STARVE_LIM = 4 * N;

    logic [N*32-1:0] grant_cnt_q;
    logic [N-1:0]    starve_q;
    logic [5:0]      wait_q [N];

    // Per-requester grant counts and wait-streak starvation flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= {(N*32){1'b0}};
            starve_q    <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                wait_q[i] <= 6'd0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_accept[i]) begin
                    grant_cnt_q[i*32 +: 32] <= grant_cnt_q[i*32 +: 32] + 32'd1;
                    wait_q[i]               <= 6'd0;
                    starve_q[i]             <= 1'b0;
                end else if (req_valid[i]) begin
                    if (wait_q[i] != 6'(STARVE_LIM)) begin
                        wait_q[i] <= wait_q[i] + 6'd1;
                    end else begin
                        wait_q[i] <= wait_q[i];
                    end
                    if (wait_q[i] >= 6'(STARVE_LIM - 1)) begin
                        starve_q[i] <= 1'b1;
                    end else begin
                        starve_q[i] <= starve_q[i];
                    end
                end else begin
                    wait_q[i] <= 6'd0;
                end
            end
        end
    end

    assign grant_cnt_r = grant_cnt_q;
    assign starve_r    = starve_q;
`endif

endmodule

// File: tb/tb_dcache_blocking_arb.sv
// Directed self-checking bench for dcache_blocking_arb (N=2, ID_N=8).
module tb_dcache_blocking_arb;
    import dcache_blocking_pkg::*;

    localparam int N    = 2;
    localparam int ID_N = 8;

    logic                clk;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N*OP_W-1:0]   req_op;
    logic [N*ADDR_W-1:0] req_addr;
    logic [N*DATA_W-1:0] req_data;
    logic [N-1:0]        req_accept;
    logic                fetch_valid;
    logic [OP_W-1:0]     fetch_op;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [DATA_W-1:0]   fetch_data;
    logic                fetch_accept;
    logic                commit_valid_r;
    logic                commit_load_r;
    logic [DATA_W-1:0]   commit_data_r;
    logic                commit_accept;
    logic [N-1:0]        rsp_valid_r;
    logic                rsp_load_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic                busy_r;
    logic                err_r;
`ifdef DCACHE_BLOCKING_ARB_STATS_EN
    logic [N*32-1:0]     grant_cnt_r;
    logic [N-1:0]        starve_r;
`endif

    int passes = 0;
    int total  = 0;

    dcache_blocking_arb #(.N(N), .ID_N(ID_N)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_accept     (req_accept),
        .fetch_valid    (fetch_valid),
        .fetch_op       (fetch_op),
        .fetch_addr     (fetch_addr),
        .fetch_data     (fetch_data),
        .fetch_accept   (fetch_accept),
        .commit_valid_r (commit_valid_r),
        .commit_load_r  (commit_load_r),
        .commit_data_r  (commit_data_r),
        .commit_accept  (commit_accept),
        .rsp_valid_r    (rsp_valid_r),
        .rsp_load_r     (rsp_load_r),
        .rsp_data_r     (rsp_data_r),
        .busy_r         (busy_r),
`ifdef DCACHE_BLOCKING_ARB_STATS_EN
        .grant_cnt_r    (grant_cnt_r),
        .starve_r       (starve_r),
`endif
        .err_r          (err_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        req_valid      = 2'b00;
        req_op         = {2'd1, 2'd0};
        req_addr       = {32'h200, 32'h100};
        req_data       = {32'h22, 32'h11};
        fetch_accept   = 1'b0;
        commit_valid_r = 1'b0;
        commit_load_r  = 1'b0;
        commit_data_r  = 32'h0;
        repeat (2) tick();
        chk("rst_fetch_valid", 64'(fetch_valid), 64'h0);
        chk("rst_busy", 64'(busy_r), 64'h0);
        chk("rst_err", 64'(err_r), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid_r), 64'h0);
        chk("commit_accept", 64'(commit_accept), 64'h1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Continuous requests from both: grants alternate 0,1,0.
        req_valid    = 2'b11;
        fetch_accept = 1'b1;
        #1 chk("rr_acc0", 64'(req_accept), 64'h1);
        tick();
        chk("rr_fv1", 64'(fetch_valid), 64'h1);
        chk("rr_addr1", 64'(fetch_addr), 64'h100);
        chk("rr_op1", 64'(fetch_op), 64'h0);
        chk("rr_data1", 64'(fetch_data), 64'h11);
        chk("rr_acc1", 64'(req_accept), 64'h2);
        tick();
        chk("rr_fv2", 64'(fetch_valid), 64'h1);
        chk("rr_addr2", 64'(fetch_addr), 64'h200);
        chk("rr_op2", 64'(fetch_op), 64'h1);
        chk("rr_data2", 64'(fetch_data), 64'h22);
        chk("rr_acc2", 64'(req_accept), 64'h1);
        tick();
        chk("rr_addr3", 64'(fetch_addr), 64'h100);
        req_valid = 2'b00;
        #1 chk("rr_idle_acc", 64'(req_accept), 64'h0);
        tick();
        chk("rr_drain_fv", 64'(fetch_valid), 64'h0);
        chk("rr_busy", 64'(busy_r), 64'h1);

        // Drain IDs 0,1,0.
        commit_valid_r = 1'b1; commit_load_r = 1'b1; commit_data_r = 32'hA;
        tick();
        chk("c0_rsp", 64'(rsp_valid_r), 64'h1);
        chk("c0_load", 64'(rsp_load_r), 64'h1);
        chk("c0_data", 64'(rsp_data_r), 64'hA);
        commit_load_r = 1'b0; commit_data_r = 32'hB;
        tick();
        chk("c1_rsp", 64'(rsp_valid_r), 64'h2);
        chk("c1_load", 64'(rsp_load_r), 64'h0);
        chk("c1_data", 64'(rsp_data_r), 64'hB);
        commit_load_r = 1'b1; commit_data_r = 32'hC;
        tick();
        chk("c2_rsp", 64'(rsp_valid_r), 64'h1);
        chk("c2_data", 64'(rsp_data_r), 64'hC);
        chk("c2_busy", 64'(busy_r), 64'h0);
        commit_valid_r = 1'b0;
        tick();
        chk("c3_rsp_idle", 64'(rsp_valid_r), 64'h0);
        chk("c3_err", 64'(err_r), 64'h0);

        // Pointer is at 1: issue IDs 1,0,1 then commit A,B,C.
        req_valid = 2'b11;
        #1 chk("id_acc0", 64'(req_accept), 64'h2);
        tick();
        chk("id_acc1", 64'(req_accept), 64'h1);
        tick();
        chk("id_acc2", 64'(req_accept), 64'h2);
        tick();
        req_valid = 2'b00;
        tick();
        commit_valid_r = 1'b1; commit_load_r = 1'b1; commit_data_r = 32'hA;
        tick();
        chk("id_rsp0", 64'(rsp_valid_r), 64'h2);
        chk("id_dat0", 64'(rsp_data_r), 64'hA);
        commit_data_r = 32'hB;
        tick();
        chk("id_rsp1", 64'(rsp_valid_r), 64'h1);
        chk("id_dat1", 64'(rsp_data_r), 64'hB);
        commit_data_r = 32'hC;
        tick();
        chk("id_rsp2", 64'(rsp_valid_r), 64'h2);
        chk("id_dat2", 64'(rsp_data_r), 64'hC);
        commit_valid_r = 1'b0;

        // Slot hold: requester 1 only, pipe stalls for 3 cycles.
        req_valid    = 2'b10;
        fetch_accept = 1'b0;
        #1 chk("hold_acc0", 64'(req_accept), 64'h2);
        tick();
        chk("hold_fv", 64'(fetch_valid), 64'h1);
        chk("hold_addr0", 64'(fetch_addr), 64'h200);
        req_addr = {32'h300, 32'h100};
        #1 chk("hold_acc_blk", 64'(req_accept), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_fv_k", 64'(fetch_valid), 64'h1);
            chk("hold_addr_k", 64'(fetch_addr), 64'h200);
            chk("hold_acc_k", 64'(req_accept), 64'h0);
        end
        fetch_accept = 1'b1;
        #1 chk("hold_acc_rel", 64'(req_accept), 64'h2);
        tick();
        chk("hold_new_addr", 64'(fetch_addr), 64'h300);
        req_valid = 2'b00;
        tick();
        chk("hold_fv_end", 64'(fetch_valid), 64'h0);
        chk("hold_busy", 64'(busy_r), 64'h1);
        commit_valid_r = 1'b1; commit_data_r = 32'hD;
        tick();
        chk("hold_rsp0", 64'(rsp_valid_r), 64'h2);
        commit_data_r = 32'hE;
        tick();
        chk("hold_rsp1", 64'(rsp_valid_r), 64'h2);
        chk("hold_dat1", 64'(rsp_data_r), 64'hE);
        commit_valid_r = 1'b0;

        // ID queue full: 8 grants, then blocked, even while popping.
        req_valid = 2'b01;
        for (int k = 0; k < ID_N; k++) begin
            #1 chk("full_acc_k", 64'(req_accept), 64'h1);
            tick();
        end
        #1 chk("full_block0", 64'(req_accept), 64'h0);
        tick();
        chk("full_block1", 64'(req_accept), 64'h0);
        chk("full_busy", 64'(busy_r), 64'h1);
        commit_valid_r = 1'b1; commit_load_r = 1'b0; commit_data_r = 32'h55;
        #1 chk("full_pop_block", 64'(req_accept), 64'h0);
        tick();
        chk("full_pop_rsp", 64'(rsp_valid_r), 64'h1);
        commit_valid_r = 1'b0;
        #1 chk("full_resume", 64'(req_accept), 64'h1);
        tick();
        req_valid      = 2'b00;
        commit_valid_r = 1'b1;
        for (int k = 0; k < ID_N; k++) begin
            tick();
            chk("full_drain_rsp", 64'(rsp_valid_r), 64'h1);
        end
        commit_valid_r = 1'b0;
        chk("full_drain_busy", 64'(busy_r), 64'h0);
        chk("full_drain_err", 64'(err_r), 64'h0);

        // Commit with empty queue: sticky error, no response.
        tick();
        commit_valid_r = 1'b1;
        tick();
        chk("err_set", 64'(err_r), 64'h1);
        chk("err_rsp", 64'(rsp_valid_r), 64'h0);
        commit_valid_r = 1'b0;
        tick();
        chk("err_sticky", 64'(err_r), 64'h1);
        chk("err_rsp2", 64'(rsp_valid_r), 64'h0);

        // Reset mid-stream with ops outstanding and a response pending.
        req_valid    = 2'b11;
        fetch_accept = 1'b1;
        #1 chk("mr_acc0", 64'(req_accept), 64'h2);
        tick();
        chk("mr_acc1", 64'(req_accept), 64'h1);
        tick();
        commit_valid_r = 1'b1; commit_load_r = 1'b1; commit_data_r = 32'h77;
        #1 chk("mr_acc2", 64'(req_accept), 64'h2);
        tick();
        chk("mr_rsp0", 64'(rsp_valid_r), 64'h2);
        chk("mr_dat0", 64'(rsp_data_r), 64'h77);
        commit_valid_r = 1'b0;
        #1 chk("mr_acc3", 64'(req_accept), 64'h1);
        tick();
        req_valid      = 2'b00;
        fetch_accept   = 1'b0;
        commit_valid_r = 1'b1;
        commit_data_r  = 32'h88;
        tick();
        chk("mr_rsp1", 64'(rsp_valid_r), 64'h1);
        chk("mr_fv", 64'(fetch_valid), 64'h1);
        chk("mr_busy", 64'(busy_r), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("mr_rst_fv", 64'(fetch_valid), 64'h0);
        chk("mr_rst_busy", 64'(busy_r), 64'h0);
        chk("mr_rst_rsp", 64'(rsp_valid_r), 64'h0);
        chk("mr_rst_err", 64'(err_r), 64'h0);
        commit_valid_r = 1'b0;
        req_valid      = 2'b11;
        fetch_accept   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mr_first_acc", 64'(req_accept), 64'h1);
        tick();
        chk("mr_first_fv", 64'(fetch_valid), 64'h1);
        chk("mr_first_addr", 64'(fetch_addr), 64'h100);
        req_valid = 2'b00;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
